if_stage: RTL

//  Instruction-fetch stage of the 5-stage LoongArch pipeline (pre-IF + IF).

---
 rtl/if_stage.sv | 91 +++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage (pre-IF + IF) of the 5-stage LoongArch pipeline.
// Drives the synchronous inst SRAM and offers {pc, inst} to ID over valid/allowin.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  logic [31:0] nextpc_p0;
  logic        fs_ready_go;
  logic        fs_allowin;

  logic [31:0] fs_pc_p1;
  logic        vld_p1;
  logic        buf_vld_p1;
  logic [31:0] inst_buf_p1;
  logic        br_pend;
  logic [31:0] pend_target;

  logic        stall_capture;

  // pre-IF: next fetch address, issued to the SRAM this cycle
  assign fs_ready_go = 1'b1;
  assign fs_allowin  = !vld_p1 || (fs_ready_go && ds_allowin);

  always_comb begin
    nextpc_p0 = pc_inc(fs_pc_p1);
    if (br_taken)
      nextpc_p0 = br_target;
    else if (br_pend)
      nextpc_p0 = pend_target;
  end

  assign inst_sram_en    = fs_allowin && resetn;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_addr  = nextpc_p0;
  assign inst_sram_wdata = 32'b0;

  // Latch rdata on the first stalled cycle; the SRAM output is not held while en=0.
  assign stall_capture = vld_p1 && !ds_allowin && !buf_vld_p1 && !br_taken;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fs_pc_p1   <= RESET_PC - 32'd4;
      vld_p1     <= 1'b0;
      buf_vld_p1 <= 1'b0;
      br_pend    <= 1'b0;
    end else if (fs_allowin) begin
      fs_pc_p1   <= nextpc_p0;
      vld_p1     <= 1'b1;
      buf_vld_p1 <= 1'b0;
      br_pend    <= 1'b0;
    end else if (br_taken) begin
      // Squash the stalled wrong-path instruction and remember where to go.
      vld_p1     <= 1'b0;
      buf_vld_p1 <= 1'b0;
      br_pend    <= 1'b1;
    end else if (stall_capture) begin
      buf_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (stall_capture)
      inst_buf_p1 <= inst_sram_rdata;
    if (br_taken && !fs_allowin)
      pend_target <= br_target;
  end

  // IF: offer {pc, inst} to ID
  assign fs_to_ds_valid = vld_p1 && resetn;
  assign fs_to_ds_pc    = fs_pc_p1;
  assign fs_to_ds_inst  = buf_vld_p1 ? inst_buf_p1 : inst_sram_rdata;

endmodule
